rv32e_cpu_core: RTL and testbench
=================================

Name: rv32e_cpu_core

Overview:
Single-cycle, in-order RV32E (16-register RV32I subset) integer core with separate instruction and data ports (Harvard). Each clock edge retires one instruction: fetch at PC, decode, execute, data access and writeback all happen in one cycle. It sits below the SoC memory/bus fabric, which supplies combinational-read instruction and data memories.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous and active-high despite the _n suffix; 1 = reset asserted.
instr_data  input  32  instruction word at instr_addr, valid in the same cycle.
mem_data  input  32  data memory read word at mem_addr, valid in the same cycle.
instr_addr  output  32  current PC.
mem_addr  output  32  load/store effective address (rs1 + imm), 0 when no access.
mem_wdata  output  32  store data (rs2), 0 when no store.
mem_we  output  1  data write strobe for the current cycle.
mem_re  output  1  data read strobe for the current cycle.

Behaviour:
- Reset (asynchronous, on rst_n=1): PC=RESET_PC, x1..x15=0. While in reset: instr_addr=RESET_PC, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0; no register writes. First fetch at RESET_PC is in the first cycle after release.
- Register file: 16 x 32-bit; x0 reads 0, writes to it are discarded. Two combinational read ports, one write port on the rising clock edge.
- Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Next PC: PC+4 by default; JAL PC+immJ; JALR (rs1+immI) with bit0 cleared; taken branch PC+immB. JAL/JALR write PC+4 to rd. No misalignment traps.
- Loads: mem_re=1, mem_addr=rs1+immI, all 32 address bits driven. LW uses mem_data directly; LB/LBU select byte lane mem_addr[1:0]; LH/LHU select halfword lane mem_addr[1]; sign- or zero-extend; result written to rd at the same clock edge.
- Stores: SW drives mem_we=1, mem_addr=rs1+immS, mem_wdata=rs2. SB/SH have no byte enables and execute as NOPs (mem_we=0).
- mem_we and mem_re are never both 1 and are combinational from the current instruction.
- Shifts use shamt[4:0]; arithmetic wraps mod 2^32; SLT/SLTI signed, SLTU/SLTIU unsigned (SLTIU compares against the sign-extended immediate).
- Register field with bit4 set (x16..x31), unknown opcode/funct, FENCE, ECALL and EBREAK: NOP, meaning no register write, no memory strobe, PC+4.
- Simulation-only function decode_instruction(input [31:0]) returns a string mnemonic such as "addi x1, x0, 5", or "unknown". It is callable hierarchically by benches and excluded from synthesis.

Decomposition:
- Package rv32e_pkg: opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG), funct3 constants, alu_op_t enum, RESET_PC default.
- Sub-module rv32e_alu: combinational, (a, b, alu_op) -> result. The top module holds PC, the register file, decode, branch compare, load alignment and the memory port.

Test Plan:
- Reset/release: hold rst_n=1 for 3 cycles, then release -> instr_addr=0, mem_we=mem_re=0 during reset; instr_addr 0,4,8 on subsequent cycles with NOPs.
- ALU: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x2,x1; sltu x5,x1,x2 -> x3=2, x4=0xFFFFFFF8, x5=1; addi x0,x0,7 leaves x0=0.
- Store/load: lui x6,0x1; addi x7,x0,0x55; sw x7,8(x6) -> mem_we=1, mem_addr=0x1008, mem_wdata=0x55. Then lb x8,1(x6) with mem_data=0x0000_80FF -> mem_re=1, mem_addr=0x1001, x8=0xFFFFFF80; lbu -> 0x80.
- Branch/jump: beq x1,x1,+16 at PC 0x20 -> next PC 0x30. bne not taken -> 0x24. jal x1,+0x100 at 0x40 -> PC 0x140, x1=0x44. jalr x0,1(x1) -> PC 0x44.
- Illegal: addi x16,x0,1 and opcode 0x7F -> no write, no strobes, PC+4. sb -> mem_we=0.
- Async reset mid-run: assert rst_n between clock edges while sw is in flight -> mem_we drops immediately, PC=0 without waiting for a clock edge.

Source files
------------

// File: rtl/rv32e_pkg.sv
// Shared encodings for the RV32E core: opcodes, funct3 values, ALU operations and reset PC.
package rv32e_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  // alt selects SUB/SRA; callers only raise it where the encoding allows.
  function automatic alu_op_t alu_op_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32e_alu.sv
// Combinational integer ALU; shifts use the low five bits of b.
module rv32e_alu
  import rv32e_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     alu_op,
  output logic [31:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // NOTE: every path assigns result, so no latch can be inferred here.
  always_comb begin
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'd0, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv32e_cpu_core.sv
// Single-cycle RV32E core: fetch, decode, execute, data access and writeback retire on one edge.
module rv32e_cpu_core
  import rv32e_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_data,
  input  logic [31:0] mem_data,
  output logic [31:0] instr_addr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re
);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] rf_q [16];
  logic [31:0] rf_d [16];

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  assign opcode  = instr_data[6:0];
  assign rd      = instr_data[11:7];
  assign funct3  = instr_data[14:12];
  assign rs1     = instr_data[19:15];
  assign rs2     = instr_data[24:20];
  assign funct7  = instr_data[31:25];
  assign imm_i   = {{20{instr_data[31]}}, instr_data[31:20]};
  assign imm_s   = {{20{instr_data[31]}}, instr_data[31:25], instr_data[11:7]};
  assign imm_b   = {{19{instr_data[31]}}, instr_data[31], instr_data[7], instr_data[30:25],
                    instr_data[11:8], 1'b0};
  assign imm_u   = {instr_data[31:12], 12'h000};
  assign imm_j   = {{11{instr_data[31]}}, instr_data[31], instr_data[19:12], instr_data[20],
                    instr_data[30:21], 1'b0};
  assign rs1_val = rf_q[rs1[3:0]];
  assign rs2_val = rf_q[rs2[3:0]];

  logic        legal, uses_rs1, uses_rs2, writes_rd, valid;
  logic [31:0] alu_a, alu_b, alu_res;
  alu_op_t     alu_op;

  always_comb begin
    legal     = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    alu_a     = rs1_val;
    alu_b     = imm_i;
    alu_op    = ALU_ADD;
    case (opcode)
      OP_LUI:    begin legal = 1'b1; writes_rd = 1'b1; alu_a = '0; alu_b = imm_u; end
      OP_AUIPC:  begin legal = 1'b1; writes_rd = 1'b1; alu_a = pc_q; alu_b = imm_u; end
      OP_JAL:    begin legal = 1'b1; writes_rd = 1'b1; end
      OP_JALR:   begin legal = (funct3 == 3'd0); writes_rd = 1'b1; uses_rs1 = 1'b1; end
      OP_BRANCH: begin legal = (funct3[2:1] != 2'b01); uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_LOAD: begin
        legal     = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
      end
      OP_STORE: begin
        legal    = (funct3 == F3_SW);
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        alu_b    = imm_s;
      end
      OP_IMM: begin
        legal = (funct3 == F3_SLL) ? (funct7 == 7'h00) :
                (funct3 == F3_SR)  ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1;
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        alu_op    = alu_op_decode(funct3, funct3 == F3_SR && funct7[5]);
      end
      OP_REG: begin
        legal = (funct7 == 7'h00) || (funct7 == 7'h20 && (funct3 == F3_ADD || funct3 == F3_SR));
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        alu_b     = rs2_val;
        alu_op    = alu_op_decode(funct3, funct7[5]);
      end
      default: ;
    endcase
  end

  // x16..x31 do not exist on RV32E, so any reference to them turns the instruction into a NOP.
  assign valid = legal && !(writes_rd && rd[4]) && !(uses_rs1 && rs1[4]) && !(uses_rs2 && rs2[4]);

  rv32e_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_res)
  );

  logic        br_taken;
  logic [31:0] byte_lane, load_val, rd_wdata;
  logic [15:0] half_lane;

  always_comb begin
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val <  rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
    byte_lane = mem_data >> {alu_res[1:0], 3'b000};
    half_lane = alu_res[1] ? mem_data[31:16] : mem_data[15:0];
    case (funct3)
      F3_LB:   load_val = {{24{byte_lane[7]}}, byte_lane[7:0]};
      F3_LH:   load_val = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  load_val = {24'd0, byte_lane[7:0]};
      F3_LHU:  load_val = {16'd0, half_lane};
      default: load_val = mem_data;
    endcase
  end

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    pc_d     = pc_plus4;
    rf_d     = rf_q;
    rd_wdata = alu_res;
    if (valid) begin
      case (opcode)
        OP_JAL:    begin pc_d = pc_q + imm_j; rd_wdata = pc_plus4; end
        OP_JALR:   begin pc_d = {alu_res[31:1], 1'b0}; rd_wdata = pc_plus4; end
        OP_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
        OP_LOAD:   rd_wdata = load_val;
        default: ;
      endcase
      if (writes_rd && rd[3:0] != 4'd0) rf_d[rd[3:0]] = rd_wdata;
    end
  end

  // NOTE: the register file is reset explicitly because software relies on x1..x15 reading 0.
  // NOTE: state flops use non-blocking assignments so all of them sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc_q <= RESET_PC;
      rf_q <= '{default: '0};
    end else begin
      pc_q <= pc_d;
      rf_q <= rf_d;
    end
  end

  assign instr_addr = pc_q;
  assign mem_re     = !rst_n && valid && (opcode == OP_LOAD);
  assign mem_we     = !rst_n && valid && (opcode == OP_STORE);
  assign mem_addr   = (mem_re || mem_we) ? alu_res : 32'd0;
  assign mem_wdata  = mem_we ? rs2_val : 32'd0;

`ifndef SYNTHESIS
  function automatic string decode_instruction(input logic [31:0] ins);
    logic [4:0]  d, s1, s2;
    logic [2:0]  f;
    logic [31:0] ii, is, ib, ij;
    string       mn;
    d  = ins[11:7];
    f  = ins[14:12];
    s1 = ins[19:15];
    s2 = ins[24:20];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    mn = "";
    case (ins[6:0])
      OP_LUI:   return $sformatf("lui x%0d, 0x%0h", d, ins[31:12]);
      OP_AUIPC: return $sformatf("auipc x%0d, 0x%0h", d, ins[31:12]);
      OP_JAL:   return $sformatf("jal x%0d, %0d", d, $signed(ij));
      OP_JALR:  if (f == 3'd0) return $sformatf("jalr x%0d, %0d(x%0d)", d, $signed(ii), s1);
      OP_BRANCH: begin
        case (f)
          3'd0: mn = "beq";  3'd1: mn = "bne";  3'd4: mn = "blt";
          3'd5: mn = "bge";  3'd6: mn = "bltu"; 3'd7: mn = "bgeu";
          default: mn = "";
        endcase
        if (mn != "") return $sformatf("%s x%0d, x%0d, %0d", mn, s1, s2, $signed(ib));
      end
      OP_LOAD: begin
        case (f)
          3'd0: mn = "lb"; 3'd1: mn = "lh"; 3'd2: mn = "lw"; 3'd4: mn = "lbu"; 3'd5: mn = "lhu";
          default: mn = "";
        endcase
        if (mn != "") return $sformatf("%s x%0d, %0d(x%0d)", mn, d, $signed(ii), s1);
      end
      OP_STORE: begin
        case (f)
          3'd0: mn = "sb"; 3'd1: mn = "sh"; 3'd2: mn = "sw";
          default: mn = "";
        endcase
        if (mn != "") return $sformatf("%s x%0d, %0d(x%0d)", mn, s2, $signed(is), s1);
      end
      OP_IMM: begin
        case (f)
          3'd0: mn = "addi"; 3'd2: mn = "slti"; 3'd3: mn = "sltiu"; 3'd4: mn = "xori";
          3'd6: mn = "ori";  3'd7: mn = "andi";
          3'd1: return $sformatf("slli x%0d, x%0d, %0d", d, s1, s2);
          default: return $sformatf("%s x%0d, x%0d, %0d", ins[30] ? "srai" : "srli", d, s1, s2);
        endcase
        return $sformatf("%s x%0d, x%0d, %0d", mn, d, s1, $signed(ii));
      end
      OP_REG: begin
        case (f)
          3'd0: mn = ins[30] ? "sub" : "add"; 3'd1: mn = "sll"; 3'd2: mn = "slt";
          3'd3: mn = "sltu"; 3'd4: mn = "xor"; 3'd5: mn = ins[30] ? "sra" : "srl";
          3'd6: mn = "or";   default: mn = "and";
        endcase
        return $sformatf("%s x%0d, x%0d, x%0d", mn, d, s1, s2);
      end
      default: ;
    endcase
    return "unknown";
  endfunction
`endif

endmodule

// File: tb/tb_rv32e_cpu_core.sv
// Bench for rv32e_cpu_core: directed program plus random instructions against an ISA-level model.
module tb_rv32e_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_data, mem_data;
  logic [31:0] instr_addr, mem_addr, mem_wdata;
  logic        mem_we, mem_re;

  rv32e_cpu_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_data (instr_data),
    .mem_data   (mem_data),
    .instr_addr (instr_addr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ISA-level model state and expected port values for the instruction being executed.
  logic [31:0] m_pc;
  logic [31:0] m_x [16];
  logic        e_we, e_re;
  logic [31:0] e_addr, e_wd;
  logic [31:0] obs_pc, obs_addr, obs_wdata;
  logic        obs_we, obs_re;

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 16; i++) m_x[i] = 32'd0;
  endtask

  task automatic model_step(input logic [31:0] ins, input logic [31:0] md);
    logic [6:0]  op, f7;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [31:0] a, b, y, ii, is, ib, ij, iu, res, addr, npc;
    logic [7:0]  l8;
    logic [15:0] l16;
    logic        ok, wr, tk, alt;
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
    r1 = ins[19:15]; r2 = ins[24:20]; f7 = ins[31:25];
    a  = m_x[r1[3:0]];
    b  = m_x[r2[3:0]];
    ii = 32'($signed(ins[31:20]));
    is = 32'($signed({ins[31:25], ins[11:7]}));
    ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    iu = {ins[31:12], 12'h000};
    e_we = 0; e_re = 0; e_addr = 0; e_wd = 0;
    npc = m_pc + 4; res = 0; ok = 0; wr = 0; tk = 0;
    case (op)
      7'h37: begin ok = !rd[4]; wr = 1; res = iu; end
      7'h17: begin ok = !rd[4]; wr = 1; res = m_pc + iu; end
      7'h6F: begin ok = !rd[4]; wr = 1; res = m_pc + 4; npc = m_pc + ij; end
      7'h67: begin
        ok = f3 == 0 && !rd[4] && !r1[4]; wr = 1; res = m_pc + 4;
        npc = (a + ii) & ~32'd1;
      end
      7'h63: begin
        ok = f3 != 2 && f3 != 3 && !r1[4] && !r2[4];
        case (f3)
          3'd0: tk = a == b;
          3'd1: tk = a != b;
          3'd4: tk = $signed(a) < $signed(b);
          3'd5: tk = $signed(a) >= $signed(b);
          3'd6: tk = a < b;
          3'd7: tk = a >= b;
          default: tk = 0;
        endcase
        if (tk) npc = m_pc + ib;
      end
      7'h03: begin
        ok = (f3 <= 2 || f3 == 4 || f3 == 5) && !rd[4] && !r1[4]; wr = 1;
        addr = a + ii;
        l8   = 8'(md >> (8 * addr[1:0]));
        l16  = 16'(md >> (16 * addr[1]));
        case (f3)
          3'd0: res = 32'($signed(l8));
          3'd1: res = 32'($signed(l16));
          3'd4: res = {24'd0, l8};
          3'd5: res = {16'd0, l16};
          default: res = md;
        endcase
        if (ok) begin e_re = 1; e_addr = addr; end
      end
      7'h23: begin
        ok = f3 == 2 && !r1[4] && !r2[4];
        if (ok) begin e_we = 1; e_addr = a + is; e_wd = b; end
      end
      7'h13, 7'h33: begin
        y   = (op == 7'h13) ? ii : b;
        alt = (f7 == 7'h20);
        wr  = 1;
        ok  = !rd[4] && !r1[4] && (op == 7'h13 || !r2[4]);
        if (op == 7'h33 && f7 != 0 && !(alt && (f3 == 0 || f3 == 5))) ok = 0;
        if (op == 7'h13 && f3 == 1 && f7 != 0) ok = 0;
        if (op == 7'h13 && f3 == 5 && f7 != 0 && !alt) ok = 0;
        case (f3)
          3'd0: res = (op == 7'h33 && alt) ? a - y : a + y;
          3'd1: res = a << y[4:0];
          3'd2: res = 32'($signed(a) < $signed(y));
          3'd3: res = 32'(a < y);
          3'd4: res = a ^ y;
          3'd5: res = alt ? 32'($signed(a) >>> y[4:0]) : a >> y[4:0];
          3'd6: res = a | y;
          default: res = a & y;
        endcase
      end
      default: ok = 0;
    endcase
    if (!ok) npc = m_pc + 4;
    if (ok && wr && rd != 0) m_x[rd[3:0]] = res;
    m_pc = npc;
  endtask

  // Drives one instruction, checks all ports against the model at the falling edge, then retires it.
  task automatic step(input logic [31:0] ins, input logic [31:0] md);
    logic [31:0] exp_pc;
    string       t;
    instr_data = ins;
    mem_data   = md;
    @(negedge clk);
    exp_pc = m_pc;
    model_step(ins, md);
    obs_pc = instr_addr; obs_we = mem_we; obs_re = mem_re;
    obs_addr = mem_addr; obs_wdata = mem_wdata;
    t = $sformatf("%h", ins);
    check({"pc@", t}, instr_addr, exp_pc);
    check({"we@", t}, 32'(mem_we), 32'(e_we));
    check({"re@", t}, 32'(mem_re), 32'(e_re));
    check({"addr@", t}, mem_addr, e_addr);
    check({"wdata@", t}, mem_wdata, e_wd);
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input int r, input string tag, input logic [31:0] exp);
    step(enc_s(3'd2, 5'd0, 5'(r), 12'd0), 32'd0);
    check(tag, obs_wdata, exp);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [11:0] imm;
    rd  = 5'($urandom_range(0, 15));
    r1  = 5'($urandom_range(0, 15));
    r2  = 5'($urandom_range(0, 15));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    case ($urandom_range(0, 9))
      0: begin
        if (f3 == 3'd1) imm[11:5] = 7'd0;
        if (f3 == 3'd5) imm[11:5] = {1'b0, 1'($urandom), 5'd0};
        return enc_i(7'h13, f3, rd, r1, imm);
      end
      1: return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                      f3, rd, r1, r2);
      2: return enc_u(($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17, rd, 20'($urandom));
      3: begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 > 3'd2) f3 = f3 + 3'd1;
        return enc_i(7'h03, f3, rd, r1, imm);
      end
      4: return enc_s(3'($urandom_range(0, 2)), r1, r2, imm);
      5: begin
        f3 = 3'($urandom_range(0, 5));
        if (f3 > 3'd1) f3 = f3 + 3'd2;
        return enc_b(f3, r1, r2, 13'($urandom));
      end
      6: return enc_j(rd, 21'($urandom));
      7: return enc_i(7'h67, 3'd0, rd, r1, imm);
      8: return $urandom;
      default: return enc_i(7'h13, 3'd0, rd | 5'd16, r1, imm);
    endcase
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    logic [31:0] p;
    rst_n      = 1'b1;
    instr_data = enc_s(3'd2, 5'd0, 5'd0, 12'd4);
    mem_data   = 32'd0;
    model_reset();

    // Reset held: a store on the bus must not strobe.
    repeat (3) begin
      @(negedge clk);
      check("rst_pc", instr_addr, 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_re", 32'(mem_re), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step(NOP, $urandom);
      check("nop_pc", obs_pc, 32'(4 * i));
    end

    step(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5), 32'd0);
    step(enc_i(7'h13, 3'd0, 5'd2, 5'd0, 12'hFFD), 32'd0);
    step(enc_r(7'h00, 3'd0, 5'd3, 5'd1, 5'd2), 32'd0);
    step(enc_r(7'h20, 3'd0, 5'd4, 5'd2, 5'd1), 32'd0);
    step(enc_r(7'h00, 3'd3, 5'd5, 5'd1, 5'd2), 32'd0);
    step(enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd7), 32'd0);
    peek(3, "x3_add", 32'd2);
    peek(4, "x4_sub", 32'hFFFF_FFF8);
    peek(5, "x5_sltu", 32'd1);
    peek(0, "x0_zero", 32'd0);

    step(enc_u(7'h37, 5'd6, 20'h00001), 32'd0);
    step(enc_i(7'h13, 3'd0, 5'd7, 5'd0, 12'h055), 32'd0);
    step(enc_s(3'd2, 5'd6, 5'd7, 12'd8), 32'd0);
    check("sw_we", 32'(obs_we), 32'd1);
    check("sw_addr", obs_addr, 32'h0000_1008);
    check("sw_wdata", obs_wdata, 32'h55);
    step(enc_i(7'h03, 3'd0, 5'd8, 5'd6, 12'd1), 32'h0000_80FF);
    check("lb_re", 32'(obs_re), 32'd1);
    check("lb_addr", obs_addr, 32'h0000_1001);
    step(enc_i(7'h03, 3'd4, 5'd9, 5'd6, 12'd1), 32'h0000_80FF);
    peek(8, "x8_lb", 32'hFFFF_FF80);
    peek(9, "x9_lbu", 32'h0000_0080);

    p = m_pc;
    step(enc_b(3'd0, 5'd1, 5'd1, 13'd16), 32'd0);
    check("beq_taken", instr_addr, p + 32'd16);
    p = m_pc;
    step(enc_b(3'd1, 5'd1, 5'd1, 13'd16), 32'd0);
    check("bne_not_taken", instr_addr, p + 32'd4);
    p = m_pc;
    step(enc_j(5'd1, 21'h100), 32'd0);
    check("jal_pc", instr_addr, p + 32'h100);
    step(enc_i(7'h67, 3'd0, 5'd0, 5'd1, 12'd1), 32'd0);
    check("jalr_pc", instr_addr, p + 32'd4);
    peek(1, "jal_link", p + 32'd4);

    step(enc_i(7'h13, 3'd0, 5'd17, 5'd0, 12'd1), 32'd0);
    step(32'h0000_007F, 32'd0);
    step(32'h0000_0073, 32'd0);
    step(32'h0000_000F, 32'd0);
    step(enc_s(3'd0, 5'd6, 5'd7, 12'd0), 32'd0);
    check("sb_nop_we", 32'(obs_we), 32'd0);
    peek(1, "x1_kept", p + 32'd4);

    // Assert reset between edges while a store is on the bus.
    instr_data = enc_s(3'd2, 5'd6, 5'd7, 12'd8);
    @(negedge clk);
    check("arst_we_before", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b1;
    #1;
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_pc", instr_addr, 32'd0);
    check("arst_addr", mem_addr, 32'd0);
    check("arst_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    peek(7, "x7_after_rst", 32'd0);

    repeat (400) step(rand_instr(), $urandom);
    for (int r = 0; r < 16; r++) step(enc_s(3'd2, 5'd0, 5'(r), 12'd0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
